// File: rtl/seven_segment_scan_display_if.sv
// Bundle between the CPU display register side and the scanned seven-segment driver.
// master drives the display request, slave is the driver that produces the pin outputs.
interface seven_segment_scan_display_if #(
    parameter int NUM_DIGITS  = 4,
    parameter int BRIGHT_BITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blankMask;
    logic                    suppressZeros;
    logic [BRIGHT_BITS-1:0]  brightness;
    logic [6:0]              segments;
    logic [NUM_DIGITS-1:0]   digitEnable;
    logic                    frameTick;

    modport master (
        output value, load, blankMask, suppressZeros, brightness,
        input  segments, digitEnable, frameTick
    );

    modport slave (
        input  value, load, blankMask, suppressZeros, brightness,
        output segments, digitEnable, frameTick
    );
endinterface

// File: rtl/seven_segment_scan_display.sv
// Time-multiplexed hex display driver: double-buffered value, per-slot PWM brightness,
// dead time, per-digit blanking and leading-zero suppression, all outputs registered.
module seven_segment_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 25000,
    parameter int DEAD_CYCLES = 4,
    parameter int BRIGHT_BITS = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rstN,
    seven_segment_scan_display_if.slave  bus
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] glyph;
        case (nib)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            4'hF:    glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
        return glyph;
    endfunction

    logic [DIV_W-1:0]       r_div_cnt;
    logic [IDX_W-1:0]       r_digit_idx;
    logic [BRIGHT_BITS-1:0] r_pwm_cnt;
    logic [VAL_W-1:0]       r_shadow;
    logic                   r_pending;
    logic [VAL_W-1:0]       r_shown;
    logic [BRIGHT_BITS-1:0] r_slot_bright;
    logic                   r_slot_blank;
    logic [6:0]             r_segments;
    logic [NUM_DIGITS-1:0]  r_digit_enable;
    logic                   r_frame_tick;

    logic                   w_slot_end;
    logic                   w_last_digit;
    logic                   w_frame_end;
    logic [IDX_W-1:0]       w_next_idx;
    logic                   w_zero_above;
    logic                   w_suppressed;
    logic                   w_lit;
    logic [VAL_W-1:0]       w_shifted;
    logic [6:0]             w_glyph;
    logic [6:0]             w_seg_on;
    logic [6:0]             w_seg_off;

    // Slot/frame boundary detection and next digit index.
    always_comb begin
        w_slot_end   = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
        w_last_digit = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
        w_frame_end  = w_slot_end && w_last_digit;
        if (w_last_digit) begin
            w_next_idx = '0;
        end else begin
            w_next_idx = r_digit_idx + IDX_W'(1);
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        w_zero_above = 1'b1;
        w_suppressed = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_shown[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == r_digit_idx) begin
                w_suppressed = w_zero_above && bus.suppressZeros;
            end else begin
                w_suppressed = w_suppressed;
            end
        end
    end

    // Lit decision and glyph selection for the digit currently in its slot.
    always_comb begin
        w_lit = (r_div_cnt >= DIV_W'(DEAD_CYCLES)) && (r_pwm_cnt <= r_slot_bright)
                && !r_slot_blank && !w_suppressed;
        w_shifted = r_shown >> (4 * 32'(r_digit_idx));
        w_glyph   = hex_decode(w_shifted[3:0]);
        if (ACTIVE_LOW) begin
            w_seg_on  = ~w_glyph;
            w_seg_off = 7'h7F;
        end else begin
            w_seg_on  = w_glyph;
            w_seg_off = 7'h00;
        end
    end

    // Scan counters and per-slot sampled brightness/blank.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_div_cnt     <= '0;
            r_digit_idx   <= '0;
            r_pwm_cnt     <= '0;
            r_slot_bright <= '0;
            r_slot_blank  <= 1'b1;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + BRIGHT_BITS'(1);
            if (w_slot_end) begin
                r_div_cnt     <= '0;
                r_digit_idx   <= w_next_idx;
                r_slot_bright <= bus.brightness;
                r_slot_blank  <= bus.blankMask[w_next_idx];
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // Double buffer: a same-cycle load at the frame boundary bypasses the shadow.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_shown   <= '0;
        end else begin
            if (bus.load) begin
                r_shadow <= bus.value;
            end else begin
                r_shadow <= r_shadow;
            end
            if (w_frame_end && bus.load) begin
                r_shown   <= bus.value;
                r_pending <= 1'b0;
            end else if (w_frame_end && r_pending) begin
                r_shown   <= r_shadow;
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

    // Registered pin outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_segments     <= w_seg_off;
            r_digit_enable <= '0;
            r_frame_tick   <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_lit) begin
                r_segments     <= w_seg_on;
                r_digit_enable <= NUM_DIGITS'(1) << r_digit_idx;
            end else begin
                r_segments     <= w_seg_off;
                r_digit_enable <= '0;
            end
        end
    end

    assign bus.segments    = r_segments;
    assign bus.digitEnable = r_digit_enable;
    assign bus.frameTick   = r_frame_tick;
endmodule

// File: doc/seven_segment_scan_display.md
# seven_segment_scan_display

Multiplexed, time-scanned hex display driver for common-anode/cathode multi-digit seven-segment modules, the generalised successor of the board's fixed two-digit per-pin decoders. It takes a packed nibble vector from the CPU display register, double-buffers it so updates land only on frame boundaries (no tearing), and scans one digit at a time. Scanning includes PWM brightness, anti-ghosting dead time, per-digit blanking and leading-zero suppression. It sits in the board top between the CPU `displayReg` and the display pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned, ≥1; digit 0 is least significant.
- `REFRESH_DIV`, 25000: clock cycles per digit slot, ≥ `DEAD_CYCLES`+1.
- `DEAD_CYCLES`, 4: cycles at the start of each slot with all digits disabled.
- `BRIGHT_BITS`, 4: brightness/PWM counter width, ≥1.
- `ACTIVE_LOW`, 1: 1 means segment outputs are inverted (segment lit = 0).

- `clk` input 1: single clock.
- `rstN` input 1: asynchronous, active-low reset.
- `value` input 4*NUM_DIGITS: nibble i = `value[4i+3:4i]` is shown on digit i.
- `load` input 1: single-cycle strobe that captures `value` into the shadow register.
- `blankMask` input NUM_DIGITS: bit i=1 forces digit i dark.
- `suppressZeros` input 1: enables leading-zero suppression.
- `brightness` input BRIGHT_BITS: PWM duty select.
- `segments` output 7: `{g,f,e,d,c,b,a}`, bit 0 = a, polarity set by `ACTIVE_LOW`.
- `digitEnable` output NUM_DIGITS: one-hot active-high enable for the digit being driven; all zero when dark.
- `frameTick` output 1: one-cycle pulse at each frame boundary.

## Operation
- **Registers.**
  - `shadow` holds the last captured value.
  - `pending` flag.
  - `shown` is the displayed value.
  - `divCnt` counts 0..REFRESH_DIV-1.
  - `digitIdx` counts 0..NUM_DIGITS-1.
  - `pwmCnt` has BRIGHT_BITS bits and increments every cycle, wrapping freely.
  - `slotBright` and `slotBlank` are sampled per slot.
- **Load.** On `load`, `shadow`←`value` and `pending`←1. Multiple loads within one frame: the last wins.
- **Slot end** (`divCnt`=REFRESH_DIV-1):
  - `divCnt`←0.
  - `digitIdx` increments. It wraps from NUM_DIGITS-1 to 0, and that wrap is the frame boundary.
  - `slotBright`←`brightness`.
  - `slotBlank`←`blankMask[next digitIdx]`.
- **Frame boundary.**
  - `frameTick`=1 for that cycle.
  - If `pending` is set, or `load` is asserted in the same cycle, `shown` takes the newest value and `pending`←0. A same-cycle `load` bypasses `shadow` into `shown`.
- **Leading-zero suppression.** Digit i (i≥1) is suppressed when `suppressZeros` is set and nibbles i..NUM_DIGITS-1 of `shown` are all 0. Digit 0 is never suppressed.
- **Digit lit condition.** All of the following hold:
  - `divCnt` ≥ DEAD_CYCLES.
  - `pwmCnt` ≤ `slotBright`. Minimum duty is 1/2^BRIGHT_BITS; all-ones gives full duty.
  - `slotBlank` is 0.
  - The digit is not suppressed.
- **Outputs when lit.**
  - `digitEnable` = one-hot(`digitIdx`).
  - `segments` = hex decode of `shown` nibble `digitIdx`, 0–F, standard glyphs: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71 (active-high form). The result is then XORed with all-ones if `ACTIVE_LOW`.
- **Outputs when dark.** `digitEnable`=0 and `segments` = all-off code (0x7F if `ACTIVE_LOW`, else 0x00).
- **Widths.** `divCnt` and `digitIdx` use $clog2 widths (minimum 1). There are no overflow states: out-of-range counts are unreachable.

## Timing
- **Reset** (`rstN`=0, asynchronous):
  - `shadow`, `shown`, `pending`, `divCnt`, `digitIdx`, `pwmCnt`, `slotBright` ← 0, and `slotBlank` ← 1.
  - `digitEnable`=0, `segments`=all-off, `frameTick`=0.
  - All outputs hold these values for as long as reset is asserted.
- **After reset release.** The first rising edge starts slot 0. The display is dark for the first slot, because `slotBlank` reset to 1, until the first slot end.
- **Registered outputs.** `segments`, `digitEnable` and `frameTick` reflect the state of the previous cycle, i.e. one cycle of latency from the counters.
- **Load latency.** `load` at cycle t is visible on `segments` no earlier than the cycle after the next frame boundary at or after t. It is never visible mid-frame.
- **Frame period.** Exactly NUM_DIGITS×REFRESH_DIV cycles. `frameTick` pulses are spaced exactly this far apart.
- **Mid-operation reset.** All state returns to reset values immediately, and any pending load is discarded.
- **NUM_DIGITS=1.** Every slot end is a frame boundary.

## Test plan
Common setup: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, BRIGHT_BITS=2, ACTIVE_LOW=0.

- **Reset.** Hold `rstN`=0, then release with `load`=0 → `digitEnable`=0, `segments`=0x00 and `frameTick`=0 throughout reset. `frameTick` pulses every 32 cycles after release.
- **Basic scan.** `value`=16'h12AF, `load` once, `brightness`=3, `blankMask`=0 → after the next boundary, digits 0..3 show 0x71, 0x77, 0x5B, 0x06. Each is enabled for 6 of 8 cycles and never during dead time.
- **Tear-free update.** Load 16'h1111, then load 16'h2222 mid-frame → no slot within the current frame shows 2. All slots show 0x5B from the next frame, and the last load wins.
- **Leading-zero suppression.** `value`=16'h0050, `suppressZeros`=1 → digits 3 and 2 are dark, digit 1 shows 0x6D, and digit 0 shows 0x3F. With `value`=0, only digit 0 is lit (0x3F).
- **Brightness.** `brightness`=0 → each lit slot shows a duty of 1 in 4 over the post-dead-time cycles. Changing to 3 mid-slot takes effect only from the next slot.
- **Blanking and reset.** `blankMask`=4'b0100 → digit 2 never enabled. Asserting `rstN` low mid-slot with a pending load → outputs immediately return to their reset values, and the pending value is never displayed.
